mc_ctrl_sequencer: RTL and testbench

Parametrised successor to the multi-cycle CPU's inline state machine: a standalone control sequencer that drives the FETCH/DECODE/EXE/MEM/WB stage-valid signals and supports variable-latency stages, including a real EXE completion handshake. It adds a dedicated one-cycle TRAP state, masked and synchronised multi-line interrupts taken only at instruction boundaries, and registered exception bookkeeping (code, EPC, redirect) for CP0 and fetch. It sits between the five stage modules, CP0 and the fetch redirect logic.

---
 rtl/mc_ctrl_pkg.sv | 39 +++
 rtl/mc_irq_sampler.sv | 42 ++++
 rtl/mc_ctrl_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Desc     : Shared state encodings and MIPS ExcCode constants for the
//             multi-cycle control sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Sequencer state encodings (code 7 is unused and recovers to IDLE)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXE    = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXE    = ST_EXE,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_TRAP   = ST_TRAP
    } state_t;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage
`default_nettype wire

// File: rtl/mc_irq_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : mc_irq_sampler
//  Desc     : Synchronises asynchronous interrupt lines into the clk domain
//             (0, 1 or 2 flop stages) and applies the per-line mask.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_irq_sampler #(
    parameter int IRQ_W    = 6,
    parameter int IRQ_SYNC = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IRQ_W-1:0] i_irq,
    input  logic [IRQ_W-1:0] i_mask,
    output logic [IRQ_W-1:0] o_pending
);

    if (IRQ_SYNC == 0) begin : g_bypass
        // Lines already synchronous to clk: mask only
        assign o_pending = i_irq & i_mask;
    end else begin : g_sync
        logic [IRQ_SYNC-1:0][IRQ_W-1:0] r_sync;

        // Shift chain; the mask is applied after the last stage so that
        // changes to Status.IM take effect in the same cycle
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_sync <= '0;
            end else begin
                r_sync[0] <= i_irq;
                for (int i = 1; i < IRQ_SYNC; i++) begin
                    r_sync[i] <= r_sync[i-1];
                end
            end
        end

        assign o_pending = r_sync[IRQ_SYNC-1] & i_mask;
    end

endmodule
`default_nettype wire

// File: rtl/mc_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_sequencer
//  Desc     : Multi-cycle CPU control sequencer. Drives one-hot stage valids,
//             waits on variable-latency stage handshakes, enters a one-cycle
//             TRAP state for stage exceptions and boundary interrupts, and
//             keeps the registered ExcCode/EPC handed to CP0 and fetch.
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int IRQ_W    = 6,
    parameter int EXC_W    = 5,
    parameter int PC_W     = 32,
    parameter int IRQ_SYNC = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [IRQ_W-1:0] irq,
    input  logic [IRQ_W-1:0] irq_mask,
    input  logic             status_ie,
    input  logic             status_exl,
    input  logic             if_over,
    input  logic             id_over,
    input  logic             exe_over,
    input  logic             mem_over,
    input  logic             wb_over,
    input  logic             jbr_not_link,
    input  logic             eret,
    input  logic             id_exc,
    input  logic [EXC_W-1:0] id_code,
    input  logic             exe_exc,
    input  logic [EXC_W-1:0] exe_code,
    input  logic             mem_exc,
    input  logic [EXC_W-1:0] mem_code,
    input  logic [PC_W-1:0]  id_pc,
    input  logic [PC_W-1:0]  exe_pc,
    input  logic [PC_W-1:0]  mem_pc,
    input  logic [PC_W-1:0]  next_pc,
    output logic [2:0]       state,
    output logic             if_valid,
    output logic             id_valid,
    output logic             exe_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             next_fetch,
    output logic             flush,
    output logic             exc_take,
    output logic             epc_we,
    output logic [EXC_W-1:0] exc_code,
    output logic [PC_W-1:0]  exc_epc,
    output logic             redirect_vec,
    output logic             redirect_epc,
    output logic [IRQ_W-1:0] irq_pending
);

    state_t           r_state;
    logic [EXC_W-1:0] r_exc_code;
    logic [PC_W-1:0]  r_exc_epc;
    logic             r_epc_we;

    logic w_id_done;
    logic w_eret_done;
    logic w_jbr_done;
    logic w_wb_done;
    logic w_irq_ok;
    logic w_int_take;

    mc_irq_sampler #(
        .IRQ_W    (IRQ_W),
        .IRQ_SYNC (IRQ_SYNC)
    ) u_irq_sampler (
        .clk       (clk),
        .resetn    (resetn),
        .i_irq     (irq),
        .i_mask    (irq_mask),
        .o_pending (irq_pending)
    );

    // Completion qualifiers. A decode exception outranks ERET and branches,
    // and ERET outranks a branch, so each qualifier excludes the ones above.
    assign w_id_done   = (r_state == S_DECODE) && id_over;
    assign w_eret_done = w_id_done && !id_exc && eret;
    assign w_jbr_done  = w_id_done && !id_exc && !eret && jbr_not_link;
    assign w_wb_done   = (r_state == S_WB) && wb_over;

    // Interrupts are only accepted at instruction boundaries
    assign w_irq_ok    = status_ie && !status_exl && (|irq_pending);
    assign w_int_take  = (w_jbr_done || w_wb_done) && w_irq_ok;

    // Sequencer FSM plus the trap bookkeeping latched on TRAP entry
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_exc_code <= '0;
            r_exc_epc  <= '0;
            r_epc_we   <= 1'b0;
        end else begin
            r_epc_we <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (if_over) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (id_over) begin
                        if (id_exc) begin
                            r_state    <= S_TRAP;
                            r_exc_code <= id_code;
                            r_exc_epc  <= id_pc;
                            r_epc_we   <= !status_exl;
                        end else if (eret) begin
                            r_state <= S_FETCH;
                        end else if (jbr_not_link) begin
                            if (w_int_take) begin
                                r_state    <= S_TRAP;
                                r_exc_code <= EXC_W'(EXC_INT);
                                r_exc_epc  <= next_pc;
                                r_epc_we   <= 1'b1;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_state <= S_EXE;
                        end
                    end
                end
                S_EXE: begin
                    if (exe_over) begin
                        if (exe_exc) begin
                            r_state    <= S_TRAP;
                            r_exc_code <= exe_code;
                            r_exc_epc  <= exe_pc;
                            r_epc_we   <= !status_exl;
                        end else begin
                            r_state <= S_MEM;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_over) begin
                        if (mem_exc) begin
                            r_state    <= S_TRAP;
                            r_exc_code <= mem_code;
                            r_exc_epc  <= mem_pc;
                            r_epc_we   <= !status_exl;
                        end else begin
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (wb_over) begin
                        if (w_int_take) begin
                            r_state    <= S_TRAP;
                            r_exc_code <= EXC_W'(EXC_INT);
                            r_exc_epc  <= next_pc;
                            r_epc_we   <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_TRAP:  r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded straight from the state register
    assign state        = r_state;
    assign if_valid     = (r_state == S_FETCH);
    assign id_valid     = (r_state == S_DECODE);
    assign exe_valid    = (r_state == S_EXE);
    assign mem_valid    = (r_state == S_MEM);
    assign wb_valid     = (r_state == S_WB);
    assign exc_take     = (r_state == S_TRAP);
    assign redirect_vec = (r_state == S_TRAP);

    // Mealy outputs valid in the completing cycle
    assign next_fetch   = (w_jbr_done || w_wb_done) && !w_int_take;
    assign redirect_epc = w_eret_done;
    assign flush        = (r_state == S_TRAP) || w_eret_done;

    assign exc_code     = r_exc_code;
    assign exc_epc      = r_exc_epc;
    assign epc_we       = r_epc_we;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_ctrl_sequencer
//  Desc     : Self-checking bench for mc_ctrl_sequencer: directed scenarios
//             followed by randomized stimulus against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_sequencer;

    localparam int IRQ_W    = 6;
    localparam int EXC_W    = 5;
    localparam int PC_W     = 32;
    localparam int IRQ_SYNC = 2;

    logic             clk;
    logic             resetn;
    logic [IRQ_W-1:0] irq, irq_mask;
    logic             status_ie, status_exl;
    logic             if_over, id_over, exe_over, mem_over, wb_over;
    logic             jbr_not_link, eret;
    logic             id_exc, exe_exc, mem_exc;
    logic [EXC_W-1:0] id_code, exe_code, mem_code;
    logic [PC_W-1:0]  id_pc, exe_pc, mem_pc, next_pc;
    logic [2:0]       state;
    logic             if_valid, id_valid, exe_valid, mem_valid, wb_valid;
    logic             next_fetch, flush, exc_take, epc_we;
    logic [EXC_W-1:0] exc_code;
    logic [PC_W-1:0]  exc_epc;
    logic             redirect_vec, redirect_epc;
    logic [IRQ_W-1:0] irq_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int               m_state;
    logic [EXC_W-1:0] m_code;
    logic [PC_W-1:0]  m_epc;
    logic             m_we;
    logic [IRQ_W-1:0] m_hist[$];

    mc_ctrl_sequencer #(
        .IRQ_W(IRQ_W), .EXC_W(EXC_W), .PC_W(PC_W), .IRQ_SYNC(IRQ_SYNC)
    ) u_dut (
        .clk(clk), .resetn(resetn), .irq(irq), .irq_mask(irq_mask),
        .status_ie(status_ie), .status_exl(status_exl),
        .if_over(if_over), .id_over(id_over), .exe_over(exe_over),
        .mem_over(mem_over), .wb_over(wb_over),
        .jbr_not_link(jbr_not_link), .eret(eret),
        .id_exc(id_exc), .id_code(id_code), .exe_exc(exe_exc), .exe_code(exe_code),
        .mem_exc(mem_exc), .mem_code(mem_code),
        .id_pc(id_pc), .exe_pc(exe_pc), .mem_pc(mem_pc), .next_pc(next_pc),
        .state(state), .if_valid(if_valid), .id_valid(id_valid),
        .exe_valid(exe_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
        .next_fetch(next_fetch), .flush(flush), .exc_take(exc_take),
        .epc_we(epc_we), .exc_code(exc_code), .exc_epc(exc_epc),
        .redirect_vec(redirect_vec), .redirect_epc(redirect_epc),
        .irq_pending(irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic zero_inputs();
        irq = '0; irq_mask = '0; status_ie = 1'b0; status_exl = 1'b0;
        if_over = 1'b0; id_over = 1'b0; exe_over = 1'b0; mem_over = 1'b0; wb_over = 1'b0;
        jbr_not_link = 1'b0; eret = 1'b0;
        id_exc = 1'b0; exe_exc = 1'b0; mem_exc = 1'b0;
        id_code = '0; exe_code = '0; mem_code = '0;
        id_pc = '0; exe_pc = '0; mem_pc = '0; next_pc = '0;
    endtask

    // Compare all outputs mid-cycle against the model, then advance the model
    // to what the next rising edge should produce. Returns at posedge+2.
    task automatic cycle();
        logic [IRQ_W-1:0] e_pend;
        logic             irq_ok, e_nf, e_fl, e_re, take, t_we;
        logic [EXC_W-1:0] t_code;
        logic [PC_W-1:0]  t_epc;
        logic [4:0]       e_valid;
        int               nxt;
        logic             ov [6];
        logic             ex [6];
        logic [EXC_W-1:0] cd [6];
        logic [PC_W-1:0]  pc [6];

        @(negedge clk);
        if (!resetn) begin
            m_state = 0; m_code = '0; m_epc = '0; m_we = 1'b0;
            m_hist = {};
            for (int i = 0; i < IRQ_SYNC; i++) m_hist.push_back('0);
        end

        // Stage tables indexed by state number (1=FETCH .. 5=WB)
        ov = '{1'b0, if_over, id_over, exe_over, mem_over, wb_over};
        ex = '{1'b0, 1'b0, id_exc, exe_exc, mem_exc, 1'b0};
        cd = '{'0, '0, id_code, exe_code, mem_code, '0};
        pc = '{'0, '0, id_pc, exe_pc, mem_pc, '0};

        e_pend = m_hist[0] & irq_mask;
        irq_ok = status_ie && !status_exl && (e_pend != '0);
        nxt = m_state; e_nf = 0; e_fl = 0; e_re = 0; take = 0;
        t_code = '0; t_epc = '0; t_we = 0;

        if (resetn) begin
            if (m_state == 0) begin
                nxt = 1;
            end else if (m_state == 6) begin
                nxt = 1; e_fl = 1;
            end else if (ov[m_state]) begin
                if (ex[m_state]) begin
                    take = 1; t_code = cd[m_state]; t_epc = pc[m_state]; t_we = !status_exl;
                end else if (m_state == 2 && eret) begin
                    nxt = 1; e_fl = 1; e_re = 1;
                end else if ((m_state == 2 && jbr_not_link) || m_state == 5) begin
                    if (irq_ok) begin
                        take = 1; t_code = '0; t_epc = next_pc; t_we = 1;
                    end else begin
                        nxt = 1; e_nf = 1;
                    end
                end else begin
                    nxt = m_state + 1;
                end
                if (take) nxt = 6;
            end
        end

        e_valid = (m_state >= 1 && m_state <= 5) ? 5'(1 << (m_state - 1)) : 5'd0;
        check("state", 32'(state), 32'(m_state));
        check("valids", 32'({wb_valid, mem_valid, exe_valid, id_valid, if_valid}), 32'(e_valid));
        check("exc_take", 32'(exc_take), 32'(m_state == 6));
        check("redirect_vec", 32'(redirect_vec), 32'(m_state == 6));
        check("flush", 32'(flush), 32'(e_fl));
        check("next_fetch", 32'(next_fetch), 32'(e_nf));
        check("redirect_epc", 32'(redirect_epc), 32'(e_re));
        check("exc_code", 32'(exc_code), 32'(m_code));
        check("exc_epc", 32'(exc_epc), 32'(m_epc));
        check("irq_pending", 32'(irq_pending), 32'(e_pend));
        if (m_state == 6 || !resetn) check("epc_we", 32'(epc_we), 32'(m_we));

        if (resetn) begin
            if (take) begin
                m_code = t_code; m_epc = t_epc;
            end
            m_we = take ? t_we : 1'b0;
            m_hist.push_back(irq);
            void'(m_hist.pop_front());
            m_state = nxt;
        end

        @(posedge clk);
        #2;
    endtask

    task automatic rand_inputs();
        if_over      = ($urandom_range(0, 2) != 0);
        id_over      = ($urandom_range(0, 2) != 0);
        exe_over     = ($urandom_range(0, 2) != 0);
        mem_over     = ($urandom_range(0, 2) != 0);
        wb_over      = ($urandom_range(0, 2) != 0);
        jbr_not_link = ($urandom_range(0, 2) == 0);
        eret         = ($urandom_range(0, 5) == 0);
        id_exc       = ($urandom_range(0, 7) == 0);
        exe_exc      = ($urandom_range(0, 7) == 0);
        mem_exc      = ($urandom_range(0, 7) == 0);
        id_code      = EXC_W'($urandom);
        exe_code     = EXC_W'($urandom);
        mem_code     = EXC_W'($urandom);
        id_pc        = $urandom;
        exe_pc       = $urandom;
        mem_pc       = $urandom;
        next_pc      = $urandom;
        if ($urandom_range(0, 3) == 0) irq = IRQ_W'($urandom);
        irq_mask     = IRQ_W'($urandom);
        status_ie    = ($urandom_range(0, 3) != 0);
        status_exl   = ($urandom_range(0, 3) == 0);
        resetn       = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        zero_inputs();
        resetn = 1'b0;
        m_state = 0; m_code = '0; m_epc = '0; m_we = 1'b0;
        for (int i = 0; i < IRQ_SYNC; i++) m_hist.push_back('0);
        #2;

        // Reset, then IDLE -> FETCH on the first edge
        cycle();
        resetn = 1'b1;
        cycle();

        // ALU op with EXE stalled three cycles
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; cycle(); id_over = 0;
        repeat (3) cycle();
        exe_over = 1; cycle(); exe_over = 0;
        mem_over = 1; cycle(); mem_over = 0;
        wb_over = 1; next_pc = 32'h10; cycle(); wb_over = 0;

        // Decode exception RI at pc 0x40
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; id_exc = 1; id_code = 5'd10; id_pc = 32'h40; cycle();
        id_over = 0; id_exc = 0;
        cycle();
        check("dir_ri_code", 32'(exc_code), 32'd10);
        check("dir_ri_epc", exc_epc, 32'h40);

        // Interrupt on line 2 taken at WB with next_pc 0x80
        irq = 6'h04; irq_mask = 6'h04; status_ie = 1; status_exl = 0;
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; cycle(); id_over = 0;
        exe_over = 1; cycle(); exe_over = 0;
        mem_over = 1; cycle(); mem_over = 0;
        wb_over = 1; next_pc = 32'h80; cycle(); wb_over = 0;
        cycle();
        check("dir_int_code", 32'(exc_code), 32'd0);
        check("dir_int_epc", exc_epc, 32'h80);

        // Same with EXL set: no interrupt, straight back to FETCH
        status_exl = 1;
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; cycle(); id_over = 0;
        exe_over = 1; cycle(); exe_over = 0;
        mem_over = 1; cycle(); mem_over = 0;
        wb_over = 1; cycle(); wb_over = 0;
        check("dir_exl_state", 32'(state), 32'd1);

        // Memory AdEL with interrupt pending: exception wins
        status_exl = 0;
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; cycle(); id_over = 0;
        exe_over = 1; cycle(); exe_over = 0;
        mem_over = 1; mem_exc = 1; mem_code = 5'd4; mem_pc = 32'h1234; cycle();
        mem_over = 0; mem_exc = 0;
        cycle();
        check("dir_adel_code", 32'(exc_code), 32'd4);
        check("dir_adel_epc", exc_epc, 32'h1234);

        // ERET in decode
        irq = '0;
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; eret = 1; cycle(); id_over = 0; eret = 0;

        // Reset dropped in MEM
        if_over = 1; cycle(); if_over = 0;
        id_over = 1; cycle(); id_over = 0;
        exe_over = 1; cycle(); exe_over = 0;
        resetn = 0; cycle();
        resetn = 1; cycle();
        cycle();

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            rand_inputs();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
